// File: rtl/imm_gen_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// imm_gen_pipe : registered RISC-V immediate generator, 2-entry skid, tag pass
// Revision 1.0
// ============================================================================
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immtype,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic [XLEN-1:0]  r_out_imm;
  logic [XLEN-1:0]  r_skid_imm;
  logic [TAG_W-1:0] r_out_tag;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_out_ill;
  logic             r_skid_ill;
  logic [XLEN-1:0]  w_imm;
  logic             w_ill;
  logic             w_accept;
  logic             w_drain;
  logic             w_load_out;
  logic             w_load_skid;
  logic             w_skid_move;
  logic             w_unused_opcode;

  // The opcode field never contributes to any immediate.
  assign w_unused_opcode = ^in_instr[6:0];

  always_comb begin
    w_imm = '0;
    w_ill = 1'b0;
    case (in_immtype)
      3'b001:  w_imm = XLEN'($signed(in_instr[31:20]));
      3'b010:  w_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      3'b011:  w_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                      in_instr[11:8], 1'b0}));
      3'b100:  w_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                      in_instr[30:21], 1'b0}));
      3'b101:  w_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      3'b110:  w_imm = XLEN'(in_instr[19:15]);
      3'b111:  w_ill = 1'b1;
      default: w_imm = '0;
    endcase
  end

  assign w_accept = in_valid & r_in_ready & ~flush;
  assign w_drain  = (r_state != ST_EMPTY) & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load_out  = 1'b0;
    w_load_skid = 1'b0;
    w_skid_move = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_ONE;
            w_load_out  = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            w_load_out = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = ST_FULL;
            w_load_skid = 1'b1;
          end else if (w_drain) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a drain can happen
          if (w_drain) begin
            w_state_nxt = ST_ONE;
            w_skid_move = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_imm <= '0;
      r_out_tag <= '0;
      r_out_ill <= 1'b0;
    end else if (w_load_out) begin
      r_out_imm <= w_imm;
      r_out_tag <= in_tag;
      r_out_ill <= w_ill;
    end else if (w_skid_move) begin
      r_out_imm <= r_skid_imm;
      r_out_tag <= r_skid_tag;
      r_out_ill <= r_skid_ill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_imm <= '0;
      r_skid_tag <= '0;
      r_skid_ill <= 1'b0;
    end else if (w_load_skid) begin
      r_skid_imm <= w_imm;
      r_skid_tag <= in_tag;
      r_skid_ill <= w_ill;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state != ST_EMPTY);
  assign out_imm     = r_out_imm;
  assign out_tag     = r_out_tag;
  assign out_illegal = r_out_ill;

endmodule
`default_nettype wire
